// File: rtl/dec138_rr_arbiter_if.sv
// Bundle between the requesters, the round-robin arbiter and the 74x138 decoder pins.
// The arbiter's FSM state and rotation pointer are also carried here for observation.
interface dec138_rr_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic       A;
  logic       B;
  logic       C;
  logic       E1_n;
  logic       E2_n;
  logic       E3;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       timeout;
  logic [1:0] state;
  logic [2:0] ptr;

  // Handshake: a requester holds req[i] high for as long as it wants the decoder.
  // It owns the decoder only while gnt_valid=1 and gnt_id=i.
  // Pulsing done (or dropping req[i]) during that time releases the decoder.
  modport master (
    output req, done,
    input  A, B, C, E1_n, E2_n, E3, gnt_valid, gnt_id, timeout, state, ptr
  );
  modport slave (
    input  req, done,
    output A, B, C, E1_n, E2_n, E3, gnt_valid, gnt_id, timeout, state, ptr
  );
endinterface

// File: rtl/dec138_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among eight requesters.
// It enforces a bounded grant length and a blanking gap between grants.
module dec138_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned GAP      = 1
) (
  input logic               clk,
  input logic               rst,
  dec138_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  localparam logic [3:0] GAP_LIM  = 4'(GAP);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       en_q, en_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;

  logic       win_valid;
  logic [2:0] win_id;
  logic       release_now;
  logic       forced;

  // Scan from ptr upward; iterating offsets high-to-low lets the lowest offset win.
  always_comb begin
    win_valid = 1'b0;
    win_id    = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      if (bus.req[ptr_q + 3'(i)]) begin
        win_valid = 1'b1;
        win_id    = ptr_q + 3'(i);
      end
    end
  end

  // State register together with the registered outputs and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 3'd0;
      gnt_id_q   <= 3'd0;
      en_q       <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= 8'd0;
      gap_cnt_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      en_q       <= en_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Next-state logic; release causes are ranked done > withdrawal > hold limit.
  always_comb begin
    state_d     = state_q;
    release_now = 1'b0;
    forced      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_valid) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (bus.done) begin
          release_now = 1'b1;
        end else if (!bus.req[gnt_id_q]) begin
          release_now = 1'b1;
        end else if (hold_cnt_q == HOLD_LIM) begin
          release_now = 1'b1;
          forced      = 1'b1;
        end
        if (release_now) state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LIM) state_d = win_valid ? S_GRANT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    ptr_d      = ptr_q;
    gnt_id_d   = gnt_id_q;
    en_d       = (state_d == S_GRANT);
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    if (state_q != S_GRANT && state_d == S_GRANT) begin
      gnt_id_d   = win_id;
      hold_cnt_d = 8'd1;
    end
    if (state_q == S_GRANT) begin
      if (release_now) begin
        ptr_d     = gnt_id_q + 3'd1;
        gap_cnt_d = 4'd1;
        timeout_d = forced;
      end else if (hold_cnt_q < HOLD_LIM) begin
        hold_cnt_d = hold_cnt_q + 8'd1;
      end
    end
    if (state_q == S_GAP && gap_cnt_q < GAP_LIM) gap_cnt_d = gap_cnt_q + 4'd1;
  end

  // The enables come from one flop, so they always switch together.
  assign bus.A         = gnt_id_q[0];
  assign bus.B         = gnt_id_q[1];
  assign bus.C         = gnt_id_q[2];
  assign bus.E1_n      = ~en_q;
  assign bus.E2_n      = ~en_q;
  assign bus.E3        = en_q;
  assign bus.gnt_valid = en_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.timeout   = timeout_q;
  assign bus.state     = state_q;
  assign bus.ptr       = ptr_q;

endmodule

// File: doc/dec138_rr_arbiter.md
Name: dec138_rr_arbiter

Overview:
- Shares one 74x138-style 3-to-8 decoder among 8 requesters using round-robin arbitration.
- Drives the decoder select lines A/B/C and the enables E1_n/E2_n/E3, so only the granted requester's Y_n line goes low.
- Enforces a maximum grant length and a blanking gap between grants, so two decoder outputs are never active together.
- Sits between requester logic and the decoder0 instance.

Parameters:
- HOLD_MAX, 15: maximum cycles in GRANT before forced release; legal range 1..255.
- GAP, 1: decoder-disabled cycles between consecutive grants; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request vector; req[i] high means requester i wants the decoder.
- done  in  1  granted requester releases the decoder; sampled only in GRANT.
- A  out  1  decoder select bit 0, equal to gnt_id[0].
- B  out  1  decoder select bit 1, equal to gnt_id[1].
- C  out  1  decoder select bit 2, equal to gnt_id[2].
- E1_n  out  1  decoder enable, active low.
- E2_n  out  1  decoder enable, active low.
- E3  out  1  decoder enable, active high.
- gnt_valid  out  1  high while in GRANT.
- gnt_id  out  3  index of the current or last granted requester.
- timeout  out  1  one-cycle pulse on a forced release.

Behaviour:
- All outputs are registered.
- Reset values, applied asynchronously: state=IDLE, ptr=0, gnt_id=0, A=B=C=0, E1_n=1, E2_n=1, E3=0, gnt_valid=0, timeout=0, hold_cnt=0, gap_cnt=0.
- Decoder enabled means E1_n=0, E2_n=0, E3=1. Decoder disabled means E1_n=1, E2_n=1, E3=0. The enables change only together.
- Arbitration:
  - Pick the first set bit of req, scanning from ptr upward and wrapping 7→0.
  - Winner w is registered into gnt_id.
  - A/B/C follow gnt_id at all times, including IDLE and GAP; they hold the last value there.
- IDLE:
  - Decoder disabled.
  - If req≠0 at edge N, then at edge N (outputs visible in cycle N+1): state=GRANT, gnt_id=w, decoder enabled, gnt_valid=1, hold_cnt=1.
  - Latency from request to grant is one cycle.
- GRANT:
  - Decoder enabled.
  - Each edge evaluates the release conditions in this priority order:
    1. done=1 → normal release.
    2. req[gnt_id]=0 → normal release (requester withdrew).
    3. hold_cnt==HOLD_MAX → forced release, timeout=1 for exactly one cycle.
    4. Otherwise hold_cnt increments.
  - done together with the timeout condition counts as a normal release; no timeout pulse.
  - On any release: ptr=(gnt_id+1) mod 8, state=GAP, gap_cnt=1, decoder disabled, gnt_valid=0.
- GAP:
  - Decoder disabled; done is ignored.
  - While gap_cnt<GAP, gap_cnt increments.
  - When gap_cnt==GAP, arbitrate as in IDLE: if req≠0, go directly to GRANT; else go to IDLE.
  - Minimum disabled time between grants is therefore GAP cycles.
- Fairness:
  - ptr advances only on release.
  - A sole persistent requester is re-granted after every gap.
  - With all 8 requesting, grants go 0,1,…,7,0.
- Boundary conditions:
  - req changes during GAP are seen only at the last GAP cycle.
  - done in IDLE or GAP is ignored.
  - rst asserted mid-GRANT disables the decoder immediately, without waiting for clk.
  - After rst deasserts, arbitration restarts at ptr=0.
- Arithmetic:
  - hold_cnt is 8 bits; gap_cnt is 4 bits.
  - Counters saturate and never wrap, given legal parameter values.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, req=0 → E1_n=1, E2_n=1, E3=0, gnt_valid=0, ABC=000, timeout=0 for 20 cycles.
- Single grant: req=8'b0010_0000 at cycle 0, done at cycle 4 → ABC=101 and decoder enabled in cycles 1–4; disabled in cycle 5 (GAP=1); ptr=6.
- Round robin: req=8'hFF held, done pulsed in every GRANT cycle → gnt_id sequence 0,1,…,7,0; exactly GAP disabled cycles between successive grants; never two grants overlapping.
- Timeout: HOLD_MAX=4, req=8'h08 held, done=0 → grant lasts 4 cycles, timeout pulses in the release cycle, then GAP, then regrant of 3 (ABC=011).
- Simultaneous events: done=1 in the same cycle hold_cnt==HOLD_MAX → normal release, timeout stays 0. Separately, req[gnt_id] dropped with done=0 → release in that edge.
- Async reset mid-grant: rst pulsed between clock edges while gnt_id=6 is granted → enables go to disabled immediately. After release, req=8'h41 → grant goes to 0 first (ptr reset), then 6.
